// File: rtl/uart_tx_drain_pkg.sv
// Shared UART definitions: oversample ratio, default link settings, TX state encoding.
package uart_tx_drain_pkg;

    localparam int OVERSAMPLE  = 16;
    localparam int DEF_DBIT    = 8;
    localparam int DEF_SB_TICK = 16;
    localparam int DEF_DVSR    = 54;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Counter width for a value range 0..v-1, never narrower than one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/uart_tx_drain_if.sv
// FIFO read port between the TX fifo (master) and the drain transmitter (slave).
interface uart_tx_drain_if #(
    parameter int DBIT = 8
);
    // fifo_rd_data is valid whenever fifo_empty=0; fifo_rd is a one-clk pop that is
    // only raised while fifo_empty=0, and the word is consumed on that clock edge.
    logic            fifo_empty;
    logic [DBIT-1:0] fifo_rd_data;
    logic            fifo_rd;

    modport master (output fifo_empty, output fifo_rd_data, input fifo_rd);
    modport slave  (input fifo_empty, input fifo_rd_data, output fifo_rd);
endinterface

// File: rtl/uart_tx_drain_baud_gen.sv
// Mod-DVSR counter producing the 16x oversample tick, with a synchronous clear.
module uart_tx_drain_baud_gen
    import uart_tx_drain_pkg::*;
#(
    parameter int DVSR = DEF_DVSR
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic s_tick
);
    localparam int            CW   = clog2_min1(DVSR);
    localparam logic [CW-1:0] LAST = CW'(DVSR - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        if (clr || cnt_q == LAST) cnt_d = '0;
        else                      cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign s_tick = (cnt_q == LAST);
endmodule

// File: rtl/uart_tx_drain.sv
// UART transmitter that pops one byte per frame straight from the TX fifo head and
// serialises start + data (LSB first) + optional even parity + stop.
module uart_tx_drain
    import uart_tx_drain_pkg::*;
#(
    parameter int DBIT      = DEF_DBIT,
    parameter int SB_TICK   = DEF_SB_TICK,
    parameter int DVSR      = DEF_DVSR,
    parameter int PARITY_EN = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_tx_drain_if.slave        fifo,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done_tick,
    output tx_state_e             state_dbg
);
    localparam int            SW          = clog2_min1(SB_TICK);
    localparam int            NW          = clog2_min1(DBIT);
    localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

    tx_state_e       state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            par_q, par_d;
    logic            tx_q, tx_d;
    logic            done_q, done_d;
    logic            pop;
    logic            s_tick;

    // Pop is Mealy so the byte is taken in the same cycle the fifo shows it; the
    // rst_n term keeps the strobe quiet while reset is held with data waiting.
    assign pop          = rst_n && (state_q == ST_IDLE) && !fifo.fifo_empty;
    assign fifo.fifo_rd = pop;

    uart_tx_drain_baud_gen #(.DVSR(DVSR)) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (pop),
        .s_tick (s_tick)
    );

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        par_d   = par_q;
        done_d  = 1'b0;
        if (state_q != ST_IDLE && s_tick) s_d = s_q + SW'(1);
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    b_d     = fifo.fifo_rd_data;
                    par_d   = ^fifo.fifo_rd_data;
                    s_d     = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (s_tick && s_q == S_BIT_LAST) begin
                    s_d     = '0;
                    n_d     = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (s_tick && s_q == S_BIT_LAST) begin
                    s_d = '0;
                    b_d = b_q >> 1;
                    if (n_q == N_LAST) state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    else               n_d     = n_q + NW'(1);
                end
            end
            ST_PARITY: begin
                if (s_tick && s_q == S_BIT_LAST) begin
                    s_d     = '0;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (s_tick && s_q == S_STOP_LAST) begin
                    s_d     = '0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // tx follows the next state so the line moves on the same edge as the state.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = b_d[0];
            ST_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign tx           = tx_q;
    assign tx_busy      = (state_q != ST_IDLE);
    assign tx_done_tick = done_q;
    assign state_dbg    = state_q;
endmodule
